imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 16: number of 16-bit instruction words per load (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 4: width of the write address, equal to log2(NUM_WORDS).
REQ-003 SHALL have port clk, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: single-cycle request to begin a program load.
REQ-006 SHALL have port byte_valid, input, 1: byte_data holds a valid byte.
REQ-007 SHALL have port byte_data, input, 8: incoming program byte, high byte of each word first.
REQ-008 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
REQ-009 SHALL have port we, output, 1: instruction-memory write strobe.
REQ-010 SHALL have port waddr, output, ADDR_W: instruction-memory word address.
REQ-011 SHALL have port wdata, output, 16: instruction word to write.
REQ-012 SHALL have port cpu_hold, output, 1: keeps the CPU in reset while high.
REQ-013 SHALL have port done, output, 1: load completed.
REQ-014 SHALL have port error, output, 1: checksum mismatch (checksum build only; otherwise tied 0).

Function
REQ-015 SHALL implement FSM states IDLE, HI, LO, WRITE, CHK, DONE.
REQ-016 SHALL transfer a byte only in a cycle where byte_valid and byte_ready are both 1; byte_valid without byte_ready SHALL be ignored.
REQ-017 SHALL drive byte_ready=1 only in HI, LO and CHK; it is combinational from state and does not depend on byte_valid.
REQ-018 IDLE: start=1 SHALL move to HI, clear the word counter to 0, clear the running XOR, and set cpu_hold=1.
REQ-019 HI: an accepted byte SHALL be latched as wdata[15:8], then move to LO.
REQ-020 LO: an accepted byte SHALL be latched as wdata[7:0], then move to WRITE.
REQ-021 WRITE SHALL assert we=1 for exactly one cycle with waddr = word counter and wdata = {hi, lo}; byte_ready=0.
REQ-022 After WRITE: if counter = NUM_WORDS-1, SHALL go to CHK (checksum build) or DONE (otherwise); else increment the counter and go to HI.
REQ-023 Each word SHALL take a minimum of 3 cycles (HI, LO, WRITE); the next HI byte is accepted no earlier than the cycle after we.
REQ-024 The counter SHALL never wrap during a load; waddr SHALL stay within 0..NUM_WORDS-1.
REQ-025 DONE SHALL drive done=1 and cpu_hold=0; both SHALL hold until the next start or reset.
REQ-026 start in DONE SHALL begin a new load exactly as in IDLE, clearing done and error and setting cpu_hold=1.
REQ-027 start in HI, LO, WRITE or CHK SHALL be ignored.
REQ-028 we SHALL be 0 in every state other than WRITE.

Reset
REQ-029 rst SHALL override all inputs, including simultaneous start or byte transfer.
REQ-030 On rst the block SHALL enter IDLE with cpu_hold=1, done=0, error=0, we=0, byte_ready=0, waddr=0, wdata=0, counter=0, XOR=0.
REQ-031 rst mid-load SHALL abandon the load with no further we pulse; words already written are not rolled back.

Configuration
REQ-032 SHALL use the macro IMEM_LOADER_CHECKSUM_EN to select checksum support.
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined: SHALL keep a running XOR of all accepted program bytes; in CHK SHALL accept one more byte; if it equals the XOR, set error=0, otherwise error=1; then go to DONE. done and cpu_hold release SHALL occur regardless of error.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN: SHALL have no CHK state and no XOR register, SHALL go from the last WRITE directly to DONE, and SHALL tie error to 0.

Structure
REQ-035 SHALL place the FSM state enum and the default NUM_WORDS/ADDR_W constants in the shared mips16 package.
REQ-036 SHALL be a single flat module with no sub-modules; the instruction-memory RAM lives outside this block.

Verification
REQ-037 Reset then start; stream 32 bytes 0x01,0x23,0x12,0x34,... with byte_valid held 1 -> 16 we pulses; first is waddr=0, wdata=0x0123; second is waddr=1, wdata=0x1234; done=1 and cpu_hold=0 after the last write.
REQ-038 Insert random byte_valid gaps of 0-5 cycles -> identical write sequence; no byte is lost or duplicated.
REQ-039 Assert rst after word 5 is written -> no further we; state IDLE; cpu_hold=1; a new start reloads from waddr=0.
REQ-040 Pulse start while in LO -> ignored; the load continues unaffected.
REQ-041 CHECKSUM_EN with correct XOR byte -> error=0 and done=1; with XOR^0x01 -> error=1, done=1, cpu_hold=0.
REQ-042 Assert start in DONE -> done drops the next cycle, cpu_hold=1, and a second load of all 16 words completes.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared mips16 definitions: instruction-memory loader state encoding and default sizing.
package mips16_pkg;

   localparam int DEF_NUM_WORDS = 16;
   localparam int DEF_ADDR_W    = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_CHK   = 3'd4,
      ST_DONE  = 3'd5
   } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams big-endian byte pairs into instruction memory while holding the CPU in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte that drives error.
module imem_loader
   import mips16_pkg::*;
#(
   parameter int NUM_WORDS = DEF_NUM_WORDS,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [15:0]       wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [2:0]        fsm_state
);

   // Byte handshake: a byte moves only on a rising edge where byte_valid and
   // byte_ready are both high; byte_ready is decoded from state alone.
   loader_state_t     state;
   logic [ADDR_W-1:0] cnt;
   logic              last_word;
   logic              take;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] xor_acc;
   logic       error_q;
   assign byte_ready = (state == ST_HI) || (state == ST_LO) || (state == ST_CHK);
   assign error      = error_q;
`else
   assign byte_ready = (state == ST_HI) || (state == ST_LO);
   assign error      = 1'b0;
`endif

   assign take      = byte_valid & byte_ready;
   assign last_word = (cnt == ADDR_W'(NUM_WORDS - 1));
   assign waddr     = cnt;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         wdata    <= '0;
         we       <= 1'b0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_acc  <= '0;
         error_q  <= 1'b0;
`endif
      end else begin
         we <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state    <= ST_HI;
                  cnt      <= '0;
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_acc  <= '0;
                  error_q  <= 1'b0;
`endif
               end
            end
            ST_HI: begin
               if (take) begin
                  wdata[15:8] <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_acc     <= xor_acc ^ byte_data;
`endif
                  state       <= ST_LO;
               end
            end
            ST_LO: begin
               // we is registered, so it rises together with the WRITE state.
               if (take) begin
                  wdata[7:0] <= byte_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  xor_acc    <= xor_acc ^ byte_data;
`endif
                  we         <= 1'b1;
                  state      <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state    <= ST_CHK;
`else
                  state    <= ST_DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  cnt   <= cnt + ADDR_W'(1);
                  state <= ST_HI;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHK: begin
               if (take) begin
                  error_q  <= (byte_data != xor_acc);
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= ST_DONE;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full loads, byte gaps, mid-load reset, ignored start, reload.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [2:0]  fsm_state;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [3:0]  got_addr_q[$];
   logic [15:0] got_data_q[$];
   logic [15:0] exp_q[$];

   imem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .fsm_state  (fsm_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (we === 1'b1) begin
         got_addr_q.push_back(waddr);
         got_data_q.push_back(wdata);
      end
   end

   // Program image: 0x0123, 0x1234, 0x2345, ... (each word +0x1111, 16-bit wrap).
   function automatic logic [15:0] word_of(input int i);
      return 16'h0123 + 16'(i) * 16'h1111;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      byte_valid = 1'b1;
      byte_data  = b;
      waited     = 0;
      @(negedge clk);
      while (byte_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (byte_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL byte_accept: byte_ready=%b required 1 within 50 cycles", byte_ready);
      end
      n_cmp++;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_writes(input int n_exp);
      if (got_data_q.size() !== n_exp) begin
         n_fail++;
         $display("FAIL write_count: got %0d required %0d", got_data_q.size(), n_exp);
      end
      n_cmp++;
      for (int i = 0; i < n_exp && i < got_data_q.size(); i++) begin
         if (got_addr_q[i] !== 4'(i)) begin
            n_fail++;
            $display("FAIL waddr[%0d]: got %0d required %0d", i, got_addr_q[i], i);
         end
         n_cmp++;
         if (got_data_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL wdata[%0d]: got %h required %h", i, got_data_q[i], exp_q[i]);
         end
         n_cmp++;
      end
   endtask

   task automatic run_load(input int gap_max, input bit poke_lo, input logic [7:0] chk_flip);
      logic [15:0] w;
      logic [7:0]  x;
      logic        exp_err;
      int          waited;
      x = 8'h00;
      got_addr_q.delete();
      got_data_q.delete();
      exp_q.delete();
      pulse_start();
      if (fsm_state !== 3'd1 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL after_start: state=%0d hold=%b done=%b err=%b required 1 1 0 0",
                  fsm_state, cpu_hold, done, error);
      end
      n_cmp++;
      for (int i = 0; i < 16; i++) begin
         w = word_of(i);
         exp_q.push_back(w);
         x = x ^ w[15:8] ^ w[7:0];
         send_byte(w[15:8], int'($urandom_range(0, gap_max)));
         if (poke_lo && i == 0) begin
            pulse_start();
            if (fsm_state !== 3'd2) begin
               n_fail++;
               $display("FAIL start_in_lo: state=%0d required 2", fsm_state);
            end
            n_cmp++;
         end
         send_byte(w[7:0], int'($urandom_range(0, gap_max)));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(x ^ chk_flip, 0);
      exp_err = (chk_flip != 8'h00);
`else
      exp_err = 1'b0;
`endif
      waited = 0;
      while (done !== 1'b1 && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      if (done !== 1'b1 || cpu_hold !== 1'b0) begin
         n_fail++;
         $display("FAIL load_done: done=%b hold=%b required 1 0", done, cpu_hold);
      end
      n_cmp++;
      if (error !== exp_err) begin
         n_fail++;
         $display("FAIL error_flag: got %b required %b", error, exp_err);
      end
      n_cmp++;
      check_writes(16);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      if (fsm_state !== 3'd0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: state=%0d hold=%b done=%b err=%b required 0 1 0 0",
                  fsm_state, cpu_hold, done, error);
      end
      n_cmp++;
      if (we !== 1'b0 || byte_ready !== 1'b0 || waddr !== 4'd0 || wdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_bus: we=%b rdy=%b waddr=%0d wdata=%h required 0 0 0 0000",
                  we, byte_ready, waddr, wdata);
      end
      n_cmp++;
      rst = 1'b0;
      @(posedge clk);
      #1;
      if (fsm_state !== 3'd0 || cpu_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_hold: state=%0d hold=%b required 0 1", fsm_state, cpu_hold);
      end
      n_cmp++;
   endtask

   task automatic test_basic_load();
      run_load(0, 1'b0, 8'h00);
      if (got_data_q.size() > 1 && (got_data_q[0] !== 16'h0123 || got_data_q[1] !== 16'h1234)) begin
         n_fail++;
         $display("FAIL first_words: got %h %h required 0123 1234", got_data_q[0], got_data_q[1]);
      end
      n_cmp++;
      repeat (5) @(posedge clk);
      #1;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || fsm_state !== 3'd5) begin
         n_fail++;
         $display("FAIL done_hold: done=%b hold=%b state=%0d required 1 0 5", done, cpu_hold, fsm_state);
      end
      n_cmp++;
   endtask

   task automatic test_gaps();
      run_load(5, 1'b0, 8'h00);
   endtask

   task automatic test_start_in_lo();
      run_load(2, 1'b1, 8'h00);
   endtask

   task automatic test_reset_mid();
      logic [15:0] w;
      got_addr_q.delete();
      got_data_q.delete();
      exp_q.delete();
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         w = word_of(i);
         exp_q.push_back(w);
         send_byte(w[15:8], 0);
         send_byte(w[7:0], 0);
      end
      w = word_of(5);
      send_byte(w[15:8], 1);
      byte_valid = 1'b1;
      byte_data  = w[7:0];
      rst        = 1'b1;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      byte_valid = 1'b0;
      if (fsm_state !== 3'd0 || cpu_hold !== 1'b1 || done !== 1'b0 || we !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: state=%0d hold=%b done=%b we=%b required 0 1 0 0",
                  fsm_state, cpu_hold, done, we);
      end
      n_cmp++;
      repeat (5) @(posedge clk);
      #1;
      check_writes(5);
      run_load(0, 1'b0, 8'h00);
   endtask

   task automatic test_restart_from_done();
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_restart: done=%b required 1", done);
      end
      n_cmp++;
      run_load(1, 1'b0, 8'h00);
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum_bad();
      run_load(0, 1'b0, 8'h01);
   endtask
`endif

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      test_reset();
      test_basic_load();
      test_gaps();
      test_start_in_lo();
      test_reset_mid();
      test_restart_from_done();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum_bad();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
